// File: rtl/axi_bw_sched_pkg.sv
// Shared response codes and register state type for the B-channel scheduler.
package axi_bw_sched_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL_PORT = 2'd1,
    ST_FULL_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/axi_bw_rr_arb.sv
// Round-robin picker: search starts one past the last granted source.
module axi_bw_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q, last_d;
  logic [PW-1:0] idx;
  logic          found;

  // First requester after last_q wins; pointer moves only when the grant is taken.
  always_comb begin
    gnt    = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(last_q) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        if (advance) last_d = idx;
      end
    end
  end

  // Pointer resets to the last source so source 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= PW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/axi_bw_scheduler.sv
// Merges N B-channel sources into one through a one-entry output register,
// tracks outstanding writes and injects DECERR responses when none are pending.
module axi_bw_scheduler
  import axi_bw_sched_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_ID_OUT  = AXI_ID_IN + 2,
  parameter int AXI_USER_W  = 6,
  parameter int CNT_W       = 10
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0]  bid_i,
  input  logic [N_INIT_PORT-1:0][1:0]             bresp_i,
  input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]  buser_i,
  input  logic [N_INIT_PORT-1:0]                  bvalid_i,
  output logic [N_INIT_PORT-1:0]                  bready_o,
  output logic [AXI_ID_IN-1:0]                    bid_o,
  output logic [1:0]                              bresp_o,
  output logic [AXI_USER_W-1:0]                   buser_o,
  output logic                                    bvalid_o,
  input  logic                                    bready_i,
  input  logic                                    incr_req_i,
  output logic                                    full_counter_o,
  output logic                                    outstanding_trans_o,
  input  logic                                    error_req_i,
  input  logic [AXI_ID_IN-1:0]                    error_id_i,
  input  logic [AXI_USER_W-1:0]                   error_user_i,
  output logic                                    error_gnt_o
);

  state_e                  state_q, state_d;
  logic [AXI_ID_IN-1:0]    bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [AXI_USER_W-1:0]   buser_q, buser_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    load, err_take, port_take, decr;
  logic [N_INIT_PORT-1:0]  gnt;
  logic [AXI_ID_IN-1:0]    sel_id;
  logic [1:0]              sel_resp;
  logic [AXI_USER_W-1:0]   sel_user;
  logic                    bid_hi_unused;

  // Upper source-ID bits carry routing info that is dropped on the merged channel.
  assign bid_hi_unused = ^bid_i;

  assign bvalid_o  = (state_q != ST_EMPTY);
  assign load      = (state_q == ST_EMPTY) || (bvalid_o && bready_i);
  // Errors may only be answered once every issued write has been responded to.
  assign err_take  = load && error_req_i && (cnt_q == '0);
  assign port_take = load && !err_take && (|bvalid_i);
  // Only real port responses retire an outstanding write.
  assign decr      = bvalid_o && bready_i && (state_q == ST_FULL_PORT);

  assign bready_o    = (port_take && !rst) ? gnt : '0;
  assign error_gnt_o = err_take && !rst;

  assign bid_o               = bid_q;
  assign bresp_o             = bresp_q;
  assign buser_o             = buser_q;
  assign full_counter_o      = (cnt_q == '1);
  assign outstanding_trans_o = (cnt_q != '0);

  axi_bw_rr_arb #(
    .N (N_INIT_PORT)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bvalid_i),
    .advance (port_take),
    .gnt     (gnt)
  );

  // One-hot payload mux of the round-robin winner.
  always_comb begin
    sel_id   = '0;
    sel_resp = '0;
    sel_user = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      if (gnt[i]) begin
        sel_id   = bid_i[i][AXI_ID_IN-1:0];
        sel_resp = bresp_i[i];
        sel_user = buser_i[i];
      end
    end
  end

  // Output register next state: error beats ports, empty when nothing to load.
  always_comb begin
    state_d = state_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    buser_d = buser_q;
    if (err_take) begin
      state_d = ST_FULL_ERR;
      bid_d   = error_id_i;
      bresp_d = RESP_DECERR;
      buser_d = error_user_i;
    end else if (port_take) begin
      state_d = ST_FULL_PORT;
      bid_d   = sel_id;
      bresp_d = sel_resp;
      buser_d = sel_user;
    end else if (load) begin
      state_d = ST_EMPTY;
    end
  end

  // Saturating outstanding counter; simultaneous issue and retire cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({incr_req_i, decr})
      2'b10:   if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // All scheduler state; reset drops any held response without retiring it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      bid_q   <= '0;
      bresp_q <= '0;
      buser_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bid_q   <= bid_d;
      bresp_q <= bresp_d;
      buser_q <= buser_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
